// File: rtl/exmem_prefetch_if.sv
// Wishbone slave bus bundle for the external-memory model.
// The master drives strobe/cycle/write/select/data/address and the slave
// returns the acknowledge and read data.
interface exmem_prefetch_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/exmem_prefetch.sv
// External-memory model behind the wishbone arbiter (window 0x3800_0000).
// Word-addressed SRAM with DELAYS-cycle miss/write latency and a PF_DEPTH-word
// prefetch line that serves sequential reads in one cycle after a miss.
// Optional build macro EXMEM_STATS_EN adds saturating hit/miss counters;
// without it hit_cnt_o/miss_cnt_o are tied to zero.
module exmem_prefetch #(
    parameter int ADDR_BITS = 10,
    parameter int DELAYS    = 10,
    parameter int PF_DEPTH  = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    exmem_prefetch_if.slave         wbs,
    output logic                    busy_o,
    output logic [15:0]             hit_cnt_o,
    output logic [15:0]             miss_cnt_o
);

    localparam int CNT_W  = $clog2(DELAYS);
    localparam int FILL_W = $clog2(PF_DEPTH + 1);
    localparam int OFF_W  = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int WORDS  = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_MISS_WAIT,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Request captured at sampling; later bus changes are ignored.
    logic                   r_we;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [3:0]             r_sel;
    logic [31:0]            r_wdat;

    logic [CNT_W-1:0]       r_cnt;
    logic [FILL_W-1:0]      r_fill_cnt;
    logic                   r_valid;
    logic [ADDR_BITS-1:0]   r_base;
    logic                   r_ack;
    logic [31:0]            r_dat;

    logic [31:0]            r_mem  [WORDS];
    logic [31:0]            r_line [PF_DEPTH];

    logic                   w_req;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [ADDR_BITS-1:0]   w_req_off;
    logic                   w_req_hit;
    logic [ADDR_BITS-1:0]   w_cur_off;
    logic                   w_cur_in_line;
    logic                   w_abort;
    logic                   w_wait_done;
    logic                   w_sample;
    logic                   w_ack_nxt;
    logic                   w_commit;
    logic                   w_fill_en;
    logic                   w_unused;

    assign w_req       = wbs.wbs_stb_i & wbs.wbs_cyc_i;
    assign w_idx       = wbs.wbs_adr_i[ADDR_BITS+1:2];
    // Offset arithmetic wraps modulo the array size so a line can span the top.
    assign w_req_off   = w_idx - r_base;
    assign w_req_hit   = r_valid && (w_req_off < ADDR_BITS'(PF_DEPTH));
    assign w_cur_off   = r_idx - r_base;
    assign w_cur_in_line = r_valid && (w_cur_off < ADDR_BITS'(PF_DEPTH));
    assign w_abort     = ~wbs.wbs_cyc_i;
    assign w_wait_done = (r_cnt == '0);
    assign w_fill_en   = (r_state == S_MISS_WAIT) && (r_fill_cnt < FILL_W'(PF_DEPTH));
    assign w_unused    = &{1'b0, wbs.wbs_adr_i[31:ADDR_BITS+2], wbs.wbs_adr_i[1:0]};

    assign busy_o        = (r_state != S_IDLE);
    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    // State register.
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state decode plus the per-edge strobes (sample, ack, commit).
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_sample = 1'b1;
                    if (wbs.wbs_we_i)   w_state_nxt = S_WR_WAIT;
                    else if (w_req_hit) w_state_nxt = S_HIT;
                    else                w_state_nxt = S_MISS_WAIT;
                end
            end
            S_HIT: begin
                w_ack_nxt   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_MISS_WAIT, S_WR_WAIT: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wait_done) begin
                    w_ack_nxt   = 1'b1;
                    w_commit    = (r_state == S_WR_WAIT);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, latency counter, line bookkeeping and ack/data outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_sel      <= '0;
            r_wdat     <= '0;
            r_cnt      <= '0;
            r_fill_cnt <= '0;
            r_valid    <= 1'b0;
            r_base     <= '0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
        end else begin
            r_ack <= w_ack_nxt;
            r_dat <= '0;
            if (w_sample) begin
                r_we   <= wbs.wbs_we_i;
                r_idx  <= w_idx;
                r_sel  <= wbs.wbs_sel_i;
                r_wdat <= wbs.wbs_dat_i;
                r_cnt  <= CNT_W'(DELAYS - 1);
                if (!wbs.wbs_we_i && !w_req_hit) begin
                    // Line is rebuilt from scratch; it stays invalid until the ack.
                    r_valid    <= 1'b0;
                    r_base     <= w_idx;
                    r_fill_cnt <= '0;
                end
            end
            if ((r_state == S_MISS_WAIT || r_state == S_WR_WAIT) && !w_wait_done)
                r_cnt <= r_cnt - 1'b1;
            if (w_fill_en)
                r_fill_cnt <= r_fill_cnt + 1'b1;
            if (r_state == S_MISS_WAIT && w_abort)
                r_valid <= 1'b0;
            if (r_state == S_HIT)
                r_dat <= r_line[w_cur_off[OFF_W-1:0]];
            if (r_state == S_MISS_WAIT && !w_abort && w_wait_done) begin
                r_dat   <= r_line[0];
                r_valid <= 1'b1;
            end
        end
    end

    // SRAM array: byte-lane write on the acking edge of a write.
    // NOTE: memory arrays carry no reset; their contents are undefined until written.
    always_ff @(posedge wb_clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++)
                if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_wdat[8*b +: 8];
        end
    end

    // Prefetch line: one word per cycle during a miss, lanes patched by writes.
    always_ff @(posedge wb_clk_i) begin
        if (w_fill_en) begin
            r_line[r_fill_cnt[OFF_W-1:0]] <= r_mem[r_base + ADDR_BITS'(r_fill_cnt)];
        end else if (w_commit && w_cur_in_line) begin
            for (int b = 0; b < 4; b++)
                if (r_sel[b]) r_line[w_cur_off[OFF_W-1:0]][8*b +: 8] <= r_wdat[8*b +: 8];
        end
    end

`ifdef EXMEM_STATS_EN
    logic        w_hit_ack;
    logic        w_miss_ack;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    assign w_hit_ack  = (r_state == S_HIT);
    assign w_miss_ack = (r_state == S_MISS_WAIT) && !w_abort && w_wait_done;

    // Saturating counters of acked read hits and misses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_ack && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
            if (w_miss_ack && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_exmem_prefetch.sv
// Self-checking bench for exmem_prefetch: a word-level memory/line model
// predicts latency, data, busy and counters; a negedge process compares them
// every cycle, and directed literals pin the model on the documented scenarios.
module tb_exmem_prefetch;

    localparam int ADDR_BITS = 10;
    localparam int DELAYS    = 10;
    localparam int PF_DEPTH  = 4;
    localparam int WORDS     = 1 << ADDR_BITS;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        busy_o;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    exmem_prefetch_if bus();

    exmem_prefetch #(
        .ADDR_BITS(ADDR_BITS),
        .DELAYS(DELAYS),
        .PF_DEPTH(PF_DEPTH)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_n(wb_rst_n),
        .wbs(bus),
        .busy_o(busy_o),
        .hit_cnt_o(hit_cnt_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected outputs for the current cycle, maintained by the driver.
    logic        exp_ack     = 1'b0;
    logic        exp_busy    = 1'b0;
    logic [31:0] exp_dat     = '0;
    bit          exp_dat_chk = 1'b1;

    // Behavioural model: whole-word memory image and the line as (valid, base).
    bit [31:0] m_mem   [WORDS];
    bit        m_known [WORDS];
    bit        m_valid = 1'b0;
    int        m_base  = 0;
    int        m_hit   = 0;
    int        m_miss  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef EXMEM_STATS_EN
        return (v > 65535) ? 32'd65535 : 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Per-cycle compare against the model.
    always @(negedge wb_clk_i) begin
        check("ack", {31'b0, bus.wbs_ack_o}, {31'b0, exp_ack});
        check("busy", {31'b0, busy_o}, {31'b0, exp_busy});
        if (exp_dat_chk) check("dat", bus.wbs_dat_o, exp_dat);
        check("hit_cnt", {16'b0, hit_cnt_o}, exp_cnt(m_hit));
        check("miss_cnt", {16'b0, miss_cnt_o}, exp_cnt(m_miss));
    end

    task automatic drop_bus();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    // One bus transaction. abort_at: cycle in which cyc is dropped (-1 none).
    // rst_at: cycle in which reset is asserted (-1 none). Called just after an edge.
    task automatic access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wdat, input int abort_at_in, input int rst_at,
                          output int lat, output logic [31:0] rdat);
        int          idx;
        bit          hit;
        int          len;
        int          abort_at;
        bit [31:0]   edata;
        bit          eknown;
        bit [31:0]   w;
        idx      = int'(adr[ADDR_BITS+1:2]);
        lat      = -1;
        rdat     = '0;
        hit      = !we && m_valid && (((idx - m_base) & (WORDS - 1)) < PF_DEPTH);
        len      = hit ? 1 : DELAYS;
        abort_at = hit ? -1 : abort_at_in;
        edata    = m_mem[idx];
        eknown   = m_known[idx];
        if (!we && !hit) m_valid = 1'b0;

        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = wdat;
        bus.wbs_adr_i = adr;

        for (int k = 0; k <= len + 1; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (k == rst_at) begin
                wb_rst_n    = 1'b0;
                m_valid     = 1'b0;
                m_hit       = 0;
                m_miss      = 0;
                exp_ack     = 1'b0;
                exp_busy    = 1'b0;
                exp_dat     = '0;
                exp_dat_chk = 1'b1;
                repeat (2) @(posedge wb_clk_i);
                #1;
                drop_bus();
                @(posedge wb_clk_i);
                #1;
                wb_rst_n = 1'b1;
                break;
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                exp_busy = 1'b0;
                exp_ack  = 1'b0;
                exp_dat  = '0;
                break;
            end
            exp_busy    = (k <= len);
            exp_ack     = (k == len);
            exp_dat     = '0;
            exp_dat_chk = 1'b1;
            if (k == len) begin
                if (we) begin
                    w = m_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) w[8*b +: 8] = wdat[8*b +: 8];
                    m_mem[idx]   = w;
                    m_known[idx] = m_known[idx] | (sel == 4'hF);
                end else begin
                    exp_dat     = edata;
                    exp_dat_chk = eknown;
                    if (hit) begin
                        m_hit++;
                    end else begin
                        m_miss++;
                        m_valid = 1'b1;
                        m_base  = idx;
                    end
                end
            end
            if (bus.wbs_ack_o) begin
                lat  = k;
                rdat = bus.wbs_dat_o;
            end
            if (k == abort_at || k == len + 1) drop_bus();
        end
        exp_dat_chk = 1'b1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d,
                      output int lat);
        logic [31:0] unused_d;
        access(1'b1, adr, sel, d, -1, -1, lat, unused_d);
    endtask

    task automatic rd(input logic [31:0] adr, output int lat, output logic [31:0] d);
        access(1'b0, adr, 4'hF, 32'h0, -1, -1, lat, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        int          pool_idx;
        bit          we;
        logic [3:0]  sel;
        int          ab;

        drop_bus();
        bus.wbs_sel_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;

        // Reset state is checked by the compare process while rst_n is low.
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_n = 1'b1;
        @(posedge wb_clk_i);
        #1;

        // 1: four full writes, then a miss read.
        for (int i = 0; i < 4; i++) begin
            wr(32'h3800_0010 + 32'(4 * i), 4'hF, 32'h1111_1111 * 32'(i + 1), lat);
            check("t1_wr_lat", 32'(lat), 32'd10);
        end
        rd(32'h3800_0010, lat, d);
        check("t1_rd_lat", 32'(lat), 32'd10);
        check("t1_rd_dat", d, 32'h1111_1111);

        // 2: sequential hits, then a miss past the line.
        rd(32'h3800_0014, lat, d);
        check("t2_lat14", 32'(lat), 32'd1);
        check("t2_dat14", d, 32'h2222_2222);
        rd(32'h3800_0018, lat, d);
        check("t2_lat18", 32'(lat), 32'd1);
        check("t2_dat18", d, 32'h3333_3333);
        rd(32'h3800_001C, lat, d);
        check("t2_lat1c", 32'(lat), 32'd1);
        check("t2_dat1c", d, 32'h4444_4444);
        rd(32'h3800_0020, lat, d);
        check("t2_lat20", 32'(lat), 32'd10);
`ifdef EXMEM_STATS_EN
        check("t2_hits", {16'b0, hit_cnt_o}, 32'd3);
        check("t2_miss", {16'b0, miss_cnt_o}, 32'd2);
`else
        check("t2_hits", {16'b0, hit_cnt_o}, 32'd0);
        check("t2_miss", {16'b0, miss_cnt_o}, 32'd0);
`endif

        // 3: reload line at 0x10, partial write into it, coherent hit.
        rd(32'h3800_0010, lat, d);
        wr(32'h3800_0014, 4'b0011, 32'hAABB_CCDD, lat);
        rd(32'h3800_0014, lat, d);
        check("t3_lat", 32'(lat), 32'd1);
        check("t3_dat", d, 32'h2222_CCDD);

        // 4: line wrapping at the top of memory.
        wr(32'h3800_0FFC, 4'hF, 32'hCAFE_F00D, lat);
        wr(32'h3800_0000, 4'hF, 32'h0BAD_F00D, lat);
        rd(32'h3800_0FFC, lat, d);
        check("t4_lat_top", 32'(lat), 32'd10);
        check("t4_dat_top", d, 32'hCAFE_F00D);
        rd(32'h3800_0000, lat, d);
        check("t4_lat_wrap", 32'(lat), 32'd1);
        check("t4_dat_wrap", d, 32'h0BAD_F00D);

        // 5: aborted miss leaves the line invalid.
        access(1'b0, 32'h3800_0040, 4'hF, 32'h0, 5, -1, lat, d);
        check("t5_abort_noack", 32'(lat), 32'hFFFF_FFFF);
        rd(32'h3800_0044, lat, d);
        check("t5_reread_lat", 32'(lat), 32'd10);

        // 6: reset in the middle of a write.
        wr(32'h3800_0080, 4'hF, 32'h5A5A_5A5A, lat);
        access(1'b1, 32'h3800_0080, 4'hF, 32'hDEAD_BEEF, -1, 4, lat, d);
        check("t6_noack", 32'(lat), 32'hFFFF_FFFF);
        check("t6_busy", {31'b0, busy_o}, 32'd0);
        check("t6_hits", {16'b0, hit_cnt_o}, 32'd0);
        check("t6_miss", {16'b0, miss_cnt_o}, 32'd0);
        rd(32'h3800_0080, lat, d);
        check("t6_rd_lat", 32'(lat), 32'd10);
        check("t6_rd_dat", d, 32'h5A5A_5A5A);

        // Random phase over a small pool near both ends of memory.
        for (int i = 0; i < 30; i++) begin
            pool_idx = (i < 24) ? i : (WORDS - 30 + i);
            wr({20'h38000, 10'(pool_idx), 2'b00}, 4'hF, $urandom, lat);
        end
        for (int n = 0; n < 200; n++) begin
            pool_idx = int'($urandom % 30);
            pool_idx = (pool_idx < 24) ? pool_idx : (WORDS - 30 + pool_idx);
            we  = ($urandom % 4) == 0;
            sel = we ? 4'($urandom % 16) : 4'hF;
            ab  = (($urandom % 8) == 0) ? int'($urandom % DELAYS) : -1;
            access(we, {20'h38000, 10'(pool_idx), 2'b00}, sel, $urandom, ab, -1, lat, d);
            repeat ($urandom % 3) begin
                @(posedge wb_clk_i);
                #1;
            end
        end

        repeat (2) @(posedge wb_clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exmem_prefetch.md
Name: exmem_prefetch

Overview:
Wishbone slave external-memory model at 0x3800_0000. It sits directly downstream of the wishbone arbiter's shared output, which carries CPU accesses and the FIR/QS/MM DMA traffic. Word-addressed SRAM array with DELAYS-cycle access latency. A PF_DEPTH-word prefetch line makes sequential DMA reads hit in 1 cycle after the first miss.

Parameters:
ADDR_BITS, 10, word-address width (2^10 words = 4 KB)
DELAYS, 10, miss/write latency in cycles; legal range is DELAYS >= PF_DEPTH+1
PF_DEPTH, 4, prefetch line length in words (power of 2)

Ports:
wb_clk_i  input  1  clock
wb_rst_n  input  1  reset, asynchronous, active-low
wbs_stb_i  input  1  strobe
wbs_cyc_i  input  1  cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte lane enables
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address; bits [31:ADDR_BITS+2] ignored (decoded upstream)
wbs_ack_o  output  1  single-cycle acknowledge
wbs_dat_o  output  32  read data, valid only with ack
busy_o  output  1  FSM not IDLE
hit_cnt_o  output  16  prefetch hit count (see optional feature)
miss_cnt_o  output  16  read miss count (see optional feature)

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, busy_o=0, counters=0, line invalid, FSM=IDLE. Array contents are not reset.
- Request: req = wbs_stb_i & wbs_cyc_i, sampled only in IDLE. Word index = wbs_adr_i[ADDR_BITS+1:2].
- Cycle numbering: the request is sampled on edge 0.
- Master holds stb/cyc until ack.
- wbs_ack_o is a 1-cycle pulse, followed by a mandatory IDLE cycle; the next request is sampled on the edge after ack falls.
- wbs_dat_o = 0 whenever ack = 0.
- States: IDLE, HIT, MISS_WAIT, WR_WAIT, DONE.
- Read hit: line valid and (idx - pf_base) mod 2^ADDR_BITS < PF_DEPTH.
  - IDLE -> HIT; ack with buffered word in cycle 1.
  - No array access.
- Read miss: IDLE -> MISS_WAIT.
  - Wait counter loads DELAYS-1.
  - Array reads idx, idx+1, ... idx+PF_DEPTH-1 (modulo 2^ADDR_BITS, so it wraps at top of memory), one per cycle, into the line.
  - pf_base = idx; line valid at ack.
  - ack with word idx in cycle DELAYS, then DONE -> IDLE.
- Write: IDLE -> WR_WAIT, counter loads DELAYS-1.
  - Byte-lane write is committed to the array at the ack edge (cycle DELAYS).
  - If idx is in the valid line, the same lanes in the line are updated in the same cycle (coherent).
  - sel=0000 still acks and changes nothing.
- Abort: cyc falls in MISS_WAIT/WR_WAIT -> IDLE next cycle.
  - No ack is issued and no write is committed.
  - Line is invalidated if a miss fill was in progress.
- stb/cyc, we or address changing while waiting is a protocol error; the FSM keeps the values captured at sampling.
- Async reset assertion mid-operation: all state clears immediately; no ack.

Optional Feature:
EXMEM_STATS_EN
- Defined: hit_cnt_o increments once per acked read hit; miss_cnt_o increments once per acked read miss.
  - Both counters saturate at 16'hFFFF.
  - Aborted accesses and writes are not counted.
- Undefined: both outputs are constant 0 and no counter flops are present.

Test Plan:
1. Write 0x11111111..0x44444444 to 0x3800_0010..0x3800_001C, sel=1111 -> each ack in cycle 10. Then read 0x3800_0010 -> ack cycle 10, data 0x11111111.
2. Immediately read 0x3800_0014, 0x3800_0018, 0x3800_001C -> each ack in cycle 1 with 0x22222222/0x33333333/0x44444444. Read 0x3800_0020 -> miss, ack cycle 10. With EXMEM_STATS_EN: hit=3, miss=2.
3. After line at 0x3800_0010 is loaded, write 0xAABBCCDD with sel=0011 to 0x3800_0014 -> the following hit read returns 0x2222CCDD in cycle 1.
4. Read 0x3800_0FFC (idx 1023) -> miss, data correct. Then read 0x3800_0000 -> hit in cycle 1 (line wrapped).
5. Start read miss at 0x3800_0040, drop cyc in cycle 5 -> no ack, busy_o low in cycle 6. Re-read 0x3800_0044 -> miss (line invalid).
6. Assert wb_rst_n=0 in cycle 4 of a write of 0xDEADBEEF to 0x3800_0080 -> ack never asserted, busy_o=0, counters=0. A later read of 0x3800_0080 does not return 0xDEADBEEF unless it was written earlier.
